// File: rtl/RISCV_pkg.sv
`default_nettype none
// ============================================================================
// RISCV_pkg : shared types for the load/store unit
// Rev 1.0   : initial release
// ============================================================================
package RISCV_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  mem_be_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Stores have no unsigned forms, so any funct3[2]=1 store is rejected.
    function automatic logic ls_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] || (f3 == 3'b011);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// lsu_if : core-side request and data-memory req/gnt/rvalid bundle
// Rev 1.0 : initial release
// ============================================================================
interface lsu_if;
    import RISCV_pkg::*;

    logic       lsu_valid;
    logic       lsu_we;
    logic [2:0] lsu_funct3;
    word_t      lsu_addr;
    word_t      lsu_wdata;
    logic       lsu_busy;
    logic       lsu_done;
    word_t      lsu_rdata;
    logic       lsu_err;

    logic       mem_req;
    logic       mem_we;
    word_t      mem_addr;
    mem_be_t    mem_be;
    word_t      mem_wdata;
    logic       mem_gnt;
    logic       mem_rvalid;
    word_t      mem_rdata;

    modport slave (
        input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output lsu_busy, lsu_done, lsu_rdata, lsu_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  lsu_busy, lsu_done, lsu_rdata, lsu_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : byte-lane steering for stores, lane extract + extend for loads
// Rev 1.0   : initial release
// ============================================================================
module lsu_align
    import RISCV_pkg::*;
(
    input  wire logic [2:0] i_st_funct3,
    input  wire logic [1:0] i_st_addr,
    input  wire word_t      i_st_wdata,
    output mem_be_t         o_be,
    output word_t           o_wdata,
    input  wire logic [2:0] i_ld_funct3,
    input  wire logic [1:0] i_ld_addr,
    input  wire word_t      i_ld_rdata,
    output word_t           o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_wdata;
        case (i_st_funct3)
            LS_B: begin
                o_be    = 4'b0001 << i_st_addr;
                o_wdata = {4{i_st_wdata[7:0]}};
            end
            LS_H: begin
                o_be    = 4'b0011 << {i_st_addr[1], 1'b0};
                o_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = i_ld_rdata[{i_ld_addr, 3'b000} +: 8];
    assign w_half = i_ld_addr[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_funct3)
            LS_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            LS_BU:   o_ld_data = {24'd0, w_byte};
            LS_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            LS_HU:   o_ld_data = {16'd0, w_half};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// lsu : load/store unit, core request to req/gnt/rvalid data memory port
//       Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W into errors.
// Rev 1.0 : initial release
// ============================================================================
module lsu
    import RISCV_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    lsu_if.slave      bus
);

    localparam word_t c_ADDR_MASK = word_t'(((64'd1 << ADDR_W) - 64'd1) & ~64'd3);

    lsu_state_t r_state;
    lsu_state_t w_next;

    logic       r_we;
    logic [2:0] r_funct3;
    logic [1:0] r_addr_lo;
    logic       r_err;
    word_t      r_rdata;
    word_t      r_mem_addr;
    mem_be_t    r_be;
    word_t      r_wdata;

    logic       w_accept;
    logic       w_illegal;
    logic       w_misalign;
    logic       w_fault;
    mem_be_t    w_be;
    word_t      w_wdata;
    word_t      w_ld_data;

    lsu_align u_align (
        .i_st_funct3 (bus.lsu_funct3),
        .i_st_addr   (bus.lsu_addr[1:0]),
        .i_st_wdata  (bus.lsu_wdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_addr   (r_addr_lo),
        .i_ld_rdata  (bus.mem_rdata),
        .o_ld_data   (w_ld_data)
    );

    assign w_accept  = (r_state == IDLE) && bus.lsu_valid;
    assign w_illegal = ls_illegal(bus.lsu_we, bus.lsu_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        case (bus.lsu_funct3)
            LS_H, LS_HU: w_misalign = bus.lsu_addr[0];
            LS_W:        w_misalign = |bus.lsu_addr[1:0];
            default:     ;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = w_illegal || w_misalign;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.lsu_valid)  w_next = w_fault ? RESP : REQ;
            REQ:     if (bus.mem_gnt)    w_next = r_we ? RESP : WAIT;
            WAIT:    if (bus.mem_rvalid) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.lsu_busy = (r_state != IDLE);
        bus.lsu_done = (r_state == RESP);
        bus.lsu_err  = (r_state == RESP) && r_err;
        bus.mem_req  = (r_state == REQ);
        bus.mem_we   = (r_state == REQ) && r_we;
    end

    // Request fields are frozen at accept so they stay stable through gnt stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr_lo  <= 2'b00;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_we       <= bus.lsu_we;
            r_funct3   <= bus.lsu_funct3;
            r_addr_lo  <= bus.lsu_addr[1:0];
            r_err      <= w_fault;
            r_mem_addr <= bus.lsu_addr & c_ADDR_MASK;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            if (w_fault)
                r_rdata <= '0;
        end else if ((r_state == WAIT) && bus.mem_rvalid) begin
            r_rdata    <= w_ld_data;
        end
    end

    assign bus.lsu_rdata = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_be;
    assign bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the data memory port. It takes the effective address produced by the ALU (`ALU_out32`) and the store data from `rd2`, and issues a word-aligned request with byte enables on a req/gnt/rvalid memory interface. It sign- or zero-extends load data and stalls the core via `lsu_busy` until the access completes, so the core can tolerate variable-latency memory.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width; `mem_addr` carries bits `[ADDR_W-1:2]`, zero-padded low.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lsu_valid` in 1: access request from the core; sampled only in IDLE.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010).
- `lsu_addr` in 32 (`word_t`): effective byte address from the ALU.
- `lsu_wdata` in 32 (`word_t`): store data from `rd2`, right-aligned.
- `lsu_busy` out 1: high whenever state is not IDLE; the core stalls on it.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_rdata` out 32 (`word_t`): extended load result; valid while `lsu_done` is high, and held until the next accept.
- `lsu_err` out 1: access error; valid with `lsu_done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_be` out 4, `mem_wdata` out 32: request channel.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1, `mem_rdata` in 32: load response.

## Operation
- FSM states (`lsu_state_t`): IDLE, REQ, WAIT, RESP.
- IDLE: on `lsu_valid`, register we/funct3/addr/wdata and compute `mem_be` and lane-shifted `mem_wdata`. Legal and aligned access goes to REQ; illegal or errored access goes to RESP with `lsu_err`=1.
- REQ: `mem_req`=1 and the request fields are held stable until `mem_gnt`. On `gnt`, a store goes to RESP and a load goes to WAIT.
- WAIT: on `mem_rvalid`, select the lane from `mem_rdata` using the registered addr[1:0], extend it per funct3, capture into `lsu_rdata`, and go to RESP.
- RESP: `lsu_done`=1 for one cycle, then IDLE.
- Byte enables:
  - byte access: `be` = 0001 << addr[1:0].
  - half access: `be` = 0011 << {addr[1],0}.
  - word access: `be` = 1111.
- Store data is replicated into lanes: byte ×4, half ×2.
- Illegal funct3:
  - loads: 011, 110, 111.
  - stores: any code with funct3[2]=1, or 011.
  - Result: `lsu_err`=1, no memory request, `lsu_rdata`=0.
- On a store `lsu_rdata` is unchanged.
- `lsu_valid` outside IDLE is ignored; no queueing.
- `mem_rvalid` outside WAIT is ignored. This includes a stale response after reset.
- Reset values: state IDLE; `lsu_busy`, `lsu_done`, `lsu_err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `lsu_rdata` = 0.
- Reset mid-access: `mem_req` drops at the reset edge and the in-flight transaction is abandoned.

## Timing
- Cycle 0: accept in IDLE; `lsu_busy` is high from cycle 1.
- Store, minimum: REQ with `gnt` in cycle 1, `lsu_done` in cycle 2.
- Load, minimum: REQ with `gnt` in cycle 1, `rvalid` in cycle 2 (WAIT), `lsu_done` in cycle 3.
- Memory contract: `rvalid` arrives at least one cycle after `gnt`.
- Error path: `lsu_done` with `lsu_err` in cycle 1.
- Each `gnt` or `rvalid` wait cycle adds one cycle of latency.
- A new access can be accepted the cycle after `lsu_done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is an error.
  - Error accesses go to RESP with `lsu_err`=1 and no memory request.
- Not defined:
  - No misalignment check.
  - A half access uses addr[1] only and ignores addr[0].
  - A word access ignores addr[1:0].
  - `lsu_err` reports illegal funct3 only.

## Structure
- Add to `RISCV_pkg`:
  - `lsu_state_t` enum.
  - funct3 width constants: `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`.
  - `mem_be_t` (logic [3:0]).
- Reuse `word_t`.
- Sub-module `lsu_align` (combinational):
  - store direction: lane steering, producing `be` and `wdata`.
  - load direction: lane extraction and sign/zero extension.
- The FSM, registers and handshake live in `lsu`.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `gnt` immediate -> `mem_addr` 0x100, `be` 1111, `wdata` 0xDEADBEEF; `lsu_done` in cycle 2, `lsu_err` 0.
- SB addr 0x103, wdata 0x000000A5 -> `be` 1000, `mem_wdata` 0xA5A5A5A5.
- `mem_rdata` 0x80FF7F01 for each load:
  - LB at 0x203 -> `lsu_rdata` 0xFFFFFF80.
  - LBU at 0x203 -> 0x00000080.
  - LH at 0x202 -> 0xFFFF80FF.
  - LHU at 0x200 -> 0x00007F01.
- LW with `gnt` delayed 3 cycles and `rvalid` 2 cycles later -> request fields stable while `mem_req` is high; `lsu_done` in cycle 7.
- LW at 0x102:
  - with the macro: `lsu_err`=1 in cycle 1, `mem_req` never asserted.
  - without the macro: `mem_addr` 0x100, normal completion.
- Assert `rst` while in WAIT, then deliver `rvalid` -> `mem_req`/`lsu_busy` are 0 after the edge; `rvalid` is ignored and `lsu_done` is never pulsed.
